// File: rtl/hpq_query_driver.sv
// Host-side query initiator for the hierarchical PQ search engine.
// Queries are buffered in a small FIFO and issued one at a time on the engine's
// start/x interface. The engine's done is turned into a tagged result on a
// valid/ready channel. A watchdog turns a missing done into a timeout result.
module hpq_query_driver #(
  parameter int W      = 32,
  parameter int D      = 32,
  parameter int TW     = 8,
  parameter int QDEPTH = 4,
  parameter int TMAX   = 4096
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  input  logic                      q_valid,
  output logic                      q_ready,
  input  logic [W*D-1:0]            q_data,
  input  logic [TW-1:0]             q_tag,
  output logic                      eng_start,
  output logic [W*D-1:0]            eng_x,
  input  logic                      eng_done,
  input  logic [31:0]               eng_minidx,
  output logic                      r_valid,
  input  logic                      r_ready,
  output logic [31:0]               r_idx,
  output logic [TW-1:0]             r_tag,
  output logic                      r_timeout,
  output logic                      busy,
  output logic [$clog2(QDEPTH):0]   q_count
);

  localparam int AW  = $clog2(QDEPTH);
  localparam int CW  = AW + 1;
  localparam int QW  = W * D + TW;
  localparam int WDW = $clog2(TMAX);

  localparam logic [CW-1:0]  DEPTH_C = CW'(QDEPTH);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TMAX - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_RESP
  } state_e;

  state_e           state_q, state_d;
  logic [QW-1:0]    fifo_mem [QDEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [QW-1:0]    head;
  logic             push, pop;

  logic [W*D-1:0]   eng_x_q, eng_x_d;
  logic [TW-1:0]    tag_q, tag_d;
  logic [WDW-1:0]   wd_q, wd_d;
  logic             r_valid_q, r_valid_d;
  logic [31:0]      r_idx_q, r_idx_d;
  logic [TW-1:0]    r_tag_q, r_tag_d;
  logic             r_timeout_q, r_timeout_d;

  // Ready depends only on registered occupancy; a same-cycle pop never opens it.
  assign q_ready = ena && (count_q < DEPTH_C);
  assign push    = q_valid && q_ready;
  assign pop     = ena && (state_q == S_IDLE) && (count_q != '0);
  assign head    = fifo_mem[rd_ptr_q];

  // FIFO storage: written at the tail on an accepted push.
  // NOTE: the storage array has no reset; occupancy and pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {q_data, q_tag};
  end

  // FIFO pointers and occupancy; pointers wrap naturally since QDEPTH is a power of 2.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (ena) begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FSM state and datapath registers; everything freezes while ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      eng_x_q     <= '0;
      tag_q       <= '0;
      wd_q        <= '0;
      r_valid_q   <= 1'b0;
      r_idx_q     <= '0;
      r_tag_q     <= '0;
      r_timeout_q <= 1'b0;
    end else if (ena) begin
      state_q     <= state_d;
      eng_x_q     <= eng_x_d;
      tag_q       <= tag_d;
      wd_q        <= wd_d;
      r_valid_q   <= r_valid_d;
      r_idx_q     <= r_idx_d;
      r_tag_q     <= r_tag_d;
      r_timeout_q <= r_timeout_d;
    end
  end

  // Next-state and datapath update: issue, wait for done or watchdog, hand back result.
  always_comb begin
    // NOTE: every variable gets a hold default first so no path infers a latch.
    state_d     = state_q;
    eng_x_d     = eng_x_q;
    tag_d       = tag_q;
    wd_d        = wd_q;
    r_valid_d   = r_valid_q;
    r_idx_d     = r_idx_q;
    r_tag_d     = r_tag_q;
    r_timeout_d = r_timeout_q;
    unique case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          eng_x_d = head[QW-1:TW];
          tag_d   = head[TW-1:0];
          wd_d    = '0;
          state_d = S_START;
        end
      end
      // A done seen here belongs to an earlier, abandoned search and is dropped.
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        wd_d = wd_q + WDW'(1);
        if (eng_done) begin
          r_idx_d     = eng_minidx;
          r_tag_d     = tag_q;
          r_timeout_d = 1'b0;
          r_valid_d   = 1'b1;
          state_d     = S_RESP;
        end else if (wd_q == WD_LAST) begin
          r_idx_d     = '0;
          r_tag_d     = tag_q;
          r_timeout_d = 1'b1;
          r_valid_d   = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (r_ready) begin
          r_valid_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
    endcase
  end

  // Outputs decoded from state: one-cycle start pulse and busy flag.
  always_comb begin
    eng_start = (state_q == S_START);
    busy      = (state_q != S_IDLE);
  end

  assign eng_x     = eng_x_q;
  assign r_valid   = r_valid_q;
  assign r_idx     = r_idx_q;
  assign r_tag     = r_tag_q;
  assign r_timeout = r_timeout_q;
  assign q_count   = count_q;

endmodule
